// File: rtl/rename_map_ckpt.sv
// Register-rename map table with branch checkpoints.
// Renames up to N_WAY instructions per cycle and forwards intra-group
// dependencies. Each taken branch snapshots the map so that a mispredict
// restores it in one cycle. CDB completions set physical-register ready bits.
// Checkpoint pointers wrap by natural overflow, so N_CKPT must be a power of two.
module rename_map_ckpt #(
  parameter int N_WAY  = 2,
  parameter int N_ARCH = 32,
  parameter int N_PHYS = 64,
  parameter int N_CKPT = 4,
  localparam int PR_BITS = $clog2(N_PHYS),
  localparam int CK_BITS = $clog2(N_CKPT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_WAY-1:0]           dis_valid_i,
  input  logic [N_WAY*5-1:0]         dis_src1_i,
  input  logic [N_WAY*5-1:0]         dis_src2_i,
  input  logic [N_WAY*5-1:0]         dis_dest_i,
  input  logic [N_WAY*PR_BITS-1:0]   dis_pr_new_i,
  input  logic [N_WAY-1:0]           dis_branch_i,
  output logic                       dis_ready_o,
  output logic [N_WAY*PR_BITS-1:0]   src1_pr_o,
  output logic [N_WAY*PR_BITS-1:0]   src2_pr_o,
  output logic [N_WAY-1:0]           src1_rdy_o,
  output logic [N_WAY-1:0]           src2_rdy_o,
  output logic [N_WAY*PR_BITS-1:0]   pr_old_o,
  output logic [CK_BITS-1:0]         ckpt_id_o,
  input  logic [N_WAY-1:0]           cdb_valid_i,
  input  logic [N_WAY*PR_BITS-1:0]   cdb_tag_i,
  input  logic                       recover_valid_i,
  input  logic [CK_BITS-1:0]         recover_id_i,
  input  logic                       retire_ckpt_i,
  output logic [CK_BITS:0]           ckpt_count_o
);

  localparam logic [CK_BITS:0]   CKPT_MAX = (CK_BITS+1)'(N_CKPT);
  localparam logic [CK_BITS:0]   CNT_ONE  = (CK_BITS+1)'(1);
  localparam logic [CK_BITS-1:0] PTR_ONE  = CK_BITS'(1);

  // Architectural state
  logic [PR_BITS-1:0] map_q  [N_ARCH];
  logic [PR_BITS-1:0] ckpt_q [N_CKPT][N_ARCH];
  logic [N_PHYS-1:0]  ready_q, ready_d;
  logic [CK_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CK_BITS:0]   count_q, count_d;

  // Unpacked per-slot fields
  logic [4:0]         src1 [N_WAY];
  logic [4:0]         src2 [N_WAY];
  logic [4:0]         dest [N_WAY];
  logic [PR_BITS-1:0] pr_new  [N_WAY];
  logic [PR_BITS-1:0] cdb_tag [N_WAY];

  // stage[i] is the map as seen by slot i (slots 0..i-1 applied)
  logic [PR_BITS-1:0] stage [N_WAY+1][N_ARCH];
  logic [PR_BITS-1:0] snap  [N_ARCH];

  logic               take;
  logic               alloc;
  logic               retire_ok;
  logic [CK_BITS-1:0] ckpt_diff;

  // Split the flat slot buses into per-slot fields
  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      src1[i]    = dis_src1_i[i*5 +: 5];
      src2[i]    = dis_src2_i[i*5 +: 5];
      dest[i]    = dis_dest_i[i*5 +: 5];
      pr_new[i]  = dis_pr_new_i[i*PR_BITS +: PR_BITS];
      cdb_tag[i] = cdb_tag_i[i*PR_BITS +: PR_BITS];
    end
  end

  // Apply the group's destination writes in program order; younger slots win
  always_comb begin
    stage[0] = map_q;
    for (int i = 0; i < N_WAY; i++) begin
      stage[i+1] = stage[i];
      if (dis_valid_i[i] && dest[i] != '0)
        stage[i+1][dest[i]] = pr_new[i];
    end
  end

  // Snapshot taken just after the branch slot (younger slots excluded)
  always_comb begin
    snap = stage[N_WAY];
    for (int i = N_WAY-1; i >= 0; i--) begin
      if (dis_valid_i[i] && dis_branch_i[i])
        snap = stage[i+1];
    end
  end

  assign dis_ready_o  = (count_q < CKPT_MAX) || (dis_branch_i == '0);
  assign take         = dis_ready_o && !recover_valid_i;
  assign alloc        = take && ((dis_valid_i & dis_branch_i) != '0);
  assign retire_ok    = retire_ckpt_i && (count_q != '0);
  assign ckpt_id_o    = tail_q;
  assign ckpt_count_o = count_q;
  assign ckpt_diff    = recover_id_i - head_q;

  for (genvar gi = 0; gi < N_WAY; gi++) begin : g_slot
    logic               hit1, hit2, cdb1, cdb2;
    logic [PR_BITS-1:0] pr1, pr2;

    assign pr1 = stage[gi][src1[gi]];
    assign pr2 = stage[gi][src2[gi]];

    // Detect forwarding from an older slot and same-cycle CDB wakeups
    always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      cdb1 = 1'b0;
      cdb2 = 1'b0;
      for (int j = 0; j < gi; j++) begin
        if (dis_valid_i[j] && dest[j] != '0) begin
          if (dest[j] == src1[gi]) hit1 = 1'b1;
          if (dest[j] == src2[gi]) hit2 = 1'b1;
        end
      end
      for (int k = 0; k < N_WAY; k++) begin
        if (cdb_valid_i[k] && cdb_tag[k] == pr1) cdb1 = 1'b1;
        if (cdb_valid_i[k] && cdb_tag[k] == pr2) cdb2 = 1'b1;
      end
    end

    assign src1_pr_o[gi*PR_BITS +: PR_BITS] = (src1[gi] == '0) ? '0 : pr1;
    assign src2_pr_o[gi*PR_BITS +: PR_BITS] = (src2[gi] == '0) ? '0 : pr2;
    assign src1_rdy_o[gi] = (src1[gi] == '0) || (!hit1 && (ready_q[pr1] || cdb1));
    assign src2_rdy_o[gi] = (src2[gi] == '0) || (!hit2 && (ready_q[pr2] || cdb2));
    assign pr_old_o[gi*PR_BITS +: PR_BITS]  = (dest[gi] == '0) ? '0 : stage[gi][dest[gi]];
  end

  // Ready bits: dispatch clears new destinations, CDB sets (set wins)
  always_comb begin
    ready_d = ready_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (take && dis_valid_i[i] && dest[i] != '0)
        ready_d[pr_new[i]] = 1'b0;
    end
    for (int k = 0; k < N_WAY; k++) begin
      if (cdb_valid_i[k])
        ready_d[cdb_tag[k]] = 1'b1;
    end
  end

  // Checkpoint ring pointers: recovery truncates back to recover_id
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recover_valid_i) begin
      tail_d = recover_id_i;
      if (retire_ckpt_i) begin
        head_d  = head_q + PTR_ONE;
        count_d = (ckpt_diff == '0) ? '0 : {1'b0, ckpt_diff} - CNT_ONE;
      end else begin
        count_d = {1'b0, ckpt_diff};
      end
    end else begin
      if (alloc) begin
        tail_d  = tail_q + PTR_ONE;
        count_d = count_d + CNT_ONE;
      end
      if (retire_ok) begin
        head_d  = head_q + PTR_ONE;
        count_d = count_d - CNT_ONE;
      end
    end
  end

  // Map, ready vector and pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ARCH; i++)
        map_q[i] <= PR_BITS'(i);
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (recover_valid_i)
        map_q <= ckpt_q[recover_id_i];
      else if (take)
        map_q <= stage[N_WAY];
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Checkpoint storage; contents are meaningless until allocated
  always_ff @(posedge clock) begin
    if (!reset && alloc)
      ckpt_q[tail_q] <= snap;
  end

`ifndef SYNTHESIS
  // Recovering to a checkpoint that is not in flight is a caller error
  always_ff @(posedge clock) begin
    if (!reset && recover_valid_i)
      assert ({1'b0, ckpt_diff} < count_q)
        else $error("rename_map_ckpt: recover_id %0d not in use", recover_id_i);
  end
`endif

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Scoreboard bench for rename_map_ckpt: a sequential program-order model
// predicts each cycle's outputs, a monitor compares them on the falling edge.
module tb_rename_map_ckpt;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dis_valid, dis_branch, src1_rdy, src2_rdy, cdb_valid, ckpt_id, recover_id;
  logic [9:0]  dis_src1, dis_src2, dis_dest;
  logic [11:0] dis_pr_new, src1_pr, src2_pr, pr_old, cdb_tag;
  logic        dis_ready, recover_valid, retire_ckpt;
  logic [2:0]  ckpt_count;

  always #5 clock = ~clock;

  rename_map_ckpt dut (
    .clock(clock), .reset(reset),
    .dis_valid_i(dis_valid), .dis_src1_i(dis_src1), .dis_src2_i(dis_src2),
    .dis_dest_i(dis_dest), .dis_pr_new_i(dis_pr_new), .dis_branch_i(dis_branch),
    .dis_ready_o(dis_ready), .src1_pr_o(src1_pr), .src2_pr_o(src2_pr),
    .src1_rdy_o(src1_rdy), .src2_rdy_o(src2_rdy), .pr_old_o(pr_old),
    .ckpt_id_o(ckpt_id), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
    .recover_valid_i(recover_valid), .recover_id_i(recover_id),
    .retire_ckpt_i(retire_ckpt), .ckpt_count_o(ckpt_count)
  );

  typedef logic [31:0][5:0] map_t;
  typedef struct packed { logic [1:0] id; map_t m; } ck_t;
  typedef struct packed {
    logic            rdy;
    logic [1:0][5:0] s1, s2, old;
    logic [1:0]      r1, r2;
    logic [1:0]      cid;
    logic [2:0]      cnt;
  } exp_t;

  // Reference model state
  map_t        m_map;
  logic [63:0] m_ready;
  ck_t         m_ck[$];
  logic [1:0]  m_tail;
  exp_t        exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic cdb_hit(input logic [5:0] p);
    return (cdb_valid[0] && cdb_tag[5:0] == p) || (cdb_valid[1] && cdb_tag[11:6] == p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = 6'(i);
    m_ready = '1;
    m_ck.delete();
    m_tail = 2'd0;
  endtask

  task automatic clr();
    dis_valid = '0; dis_src1 = '0; dis_src2 = '0; dis_dest = '0; dis_pr_new = '0;
    dis_branch = '0; cdb_valid = '0; cdb_tag = '0;
    recover_valid = 1'b0; recover_id = '0; retire_ckpt = 1'b0;
  endtask

  task automatic set_slot(input int i, input bit v, input int s1, input int s2,
                          input int d, input int pr, input bit br);
    dis_valid[i]         = v;
    dis_src1[i*5 +: 5]   = 5'(s1);
    dis_src2[i*5 +: 5]   = 5'(s2);
    dis_dest[i*5 +: 5]   = 5'(d);
    dis_pr_new[i*6 +: 6] = 6'(pr);
    dis_branch[i]        = br;
  endtask

  // Predict this cycle's outputs from the model, then advance the model
  task automatic issue();
    exp_t e; map_t w; logic [31:0] pend; logic [4:0] a, b, d; logic [5:0] p;
    logic taken, ret_ok; int pos; ck_t c;
    e = '0; w = m_map; pend = '0;
    e.rdy = (m_ck.size() < 4) || (dis_branch == 2'b00);
    for (int i = 0; i < 2; i++) begin
      a = dis_src1[i*5 +: 5]; b = dis_src2[i*5 +: 5]; d = dis_dest[i*5 +: 5];
      e.s1[i]  = (a == 0) ? 6'd0 : w[a];
      e.r1[i]  = (a == 0) ? 1'b1 : (pend[a] ? 1'b0 : (m_ready[w[a]] || cdb_hit(w[a])));
      e.s2[i]  = (b == 0) ? 6'd0 : w[b];
      e.r2[i]  = (b == 0) ? 1'b1 : (pend[b] ? 1'b0 : (m_ready[w[b]] || cdb_hit(w[b])));
      e.old[i] = (d == 0) ? 6'd0 : w[d];
      if (dis_valid[i] && d != 0) begin
        w[d] = dis_pr_new[i*6 +: 6];
        pend[d] = 1'b1;
      end
    end
    e.cid = m_tail;
    e.cnt = 3'(m_ck.size());
    exp_q.push_back(e);

    taken  = e.rdy && !recover_valid;
    ret_ok = retire_ckpt && (m_ck.size() > 0);
    if (recover_valid) begin
      pos = -1;
      for (int k = 0; k < m_ck.size(); k++)
        if (pos < 0 && m_ck[k].id == recover_id) pos = k;
      if (pos < 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stimulus: recover to unused id %0d", recover_id);
      end else begin
        m_map = m_ck[pos].m;
        while (m_ck.size() > pos) void'(m_ck.pop_back());
        m_tail = recover_id;
        if (retire_ckpt && m_ck.size() > 0) void'(m_ck.pop_front());
      end
    end else begin
      if (taken) begin
        w = m_map;
        for (int i = 0; i < 2; i++) begin
          d = dis_dest[i*5 +: 5]; p = dis_pr_new[i*6 +: 6];
          if (dis_valid[i] && d != 0) begin
            w[d] = p;
            m_ready[p] = 1'b0;
          end
          if (dis_valid[i] && dis_branch[i]) begin
            c.id = m_tail; c.m = w;
            m_ck.push_back(c);
            m_tail = m_tail + 2'd1;
          end
        end
        m_map = w;
      end
      if (ret_ok) void'(m_ck.pop_front());
    end
    for (int k = 0; k < 2; k++)
      if (cdb_valid[k]) m_ready[cdb_tag[k*6 +: 6]] = 1'b1;
  endtask

  task automatic cyc();
    issue();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        check("dis_ready", dis_ready, e.rdy);
        for (int i = 0; i < 2; i++) begin
          check($sformatf("src1_pr[%0d]", i), src1_pr[i*6 +: 6], e.s1[i]);
          check($sformatf("src2_pr[%0d]", i), src2_pr[i*6 +: 6], e.s2[i]);
          check($sformatf("src1_rdy[%0d]", i), src1_rdy[i], e.r1[i]);
          check($sformatf("src2_rdy[%0d]", i), src2_rdy[i], e.r2[i]);
          check($sformatf("pr_old[%0d]", i), pr_old[i*6 +: 6], e.old[i]);
        end
        check("ckpt_id", ckpt_id, e.cid);
        check("ckpt_count", ckpt_count, e.cnt);
        $display("txn %0d: v=%b br=%b rec=%b/%0d ret=%b cnt=%0d id=%0d",
                 n_txn, dis_valid, dis_branch, recover_valid, recover_id,
                 retire_ckpt, ckpt_count, ckpt_id);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    logic [1:0] bid;
    int pos;
    do_reset();

    // Simple rename from the reset map
    clr(); set_slot(0, 1, 1, 2, 5, 40, 0); cyc();
    // x5 now maps to PR40 (not ready); CDB wakes it in the same cycle
    clr(); set_slot(0, 1, 5, 0, 0, 0, 0); cdb_valid = 2'b01; cdb_tag[5:0] = 6'd40; cyc();
    clr(); set_slot(0, 1, 5, 5, 0, 0, 0); cyc();
    // Intra-group forwarding, younger slot wins the map write
    clr(); set_slot(0, 1, 0, 0, 3, 41, 0); set_slot(1, 1, 3, 1, 3, 42, 0); cyc();
    clr(); set_slot(0, 1, 3, 0, 0, 0, 0); cyc();

    // Branch in slot0 excludes slot1's write from the checkpoint
    bid = m_tail;
    clr(); set_slot(0, 1, 1, 2, 0, 0, 1); set_slot(1, 1, 0, 0, 7, 43, 0); cyc();
    clr(); set_slot(0, 1, 7, 0, 7, 44, 0); cyc();
    clr(); recover_valid = 1'b1; recover_id = bid; set_slot(0, 1, 7, 0, 7, 45, 0); cyc();
    clr(); set_slot(0, 1, 7, 3, 0, 0, 0); cyc();

    // Fill all checkpoints, then a branch group must stall
    for (int k = 0; k < 4; k++) begin
      clr(); set_slot(0, 1, k + 1, 0, k + 8, 46 + k, 0); set_slot(1, 1, k + 8, 0, 0, 0, 1); cyc();
    end
    clr(); set_slot(0, 1, 9, 0, 9, 50, 1); cyc();
    clr(); set_slot(0, 1, 9, 0, 9, 51, 0); cyc();
    clr(); retire_ckpt = 1'b1; cyc();
    clr(); set_slot(0, 1, 9, 0, 0, 0, 1); cyc();

    // Mid-operation reset returns the identity map
    do_reset();
    clr(); set_slot(0, 1, 9, 8, 9, 20, 0); set_slot(1, 1, 5, 7, 0, 0, 0); cyc();

    // Pointer wrap: alloc+retire, fill, then recover to tail-2 with retire
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clr(); set_slot(0, 1, 1, 0, 0, 0, 1); retire_ckpt = 1'b1; cyc();
    end
    for (int k = 0; k < 3; k++) begin
      clr(); set_slot(0, 1, 0, 0, k + 10, 30 + k, 1); cyc();
    end
    clr(); recover_valid = 1'b1; recover_id = m_tail - 2'd2; retire_ckpt = 1'b1; cyc();
    clr(); set_slot(0, 1, 10, 11, 0, 0, 0); cyc();
    clr(); recover_valid = 1'b1; recover_id = m_ck[0].id; cyc();
    clr(); set_slot(0, 1, 10, 12, 0, 0, 0); cyc();

    // Recover to the oldest checkpoint while retiring it: count drops to 0
    do_reset();
    clr(); set_slot(0, 1, 0, 0, 4, 33, 1); cyc();
    clr(); recover_valid = 1'b1; recover_id = m_ck[0].id; retire_ckpt = 1'b1; cyc();
    clr(); set_slot(0, 1, 4, 0, 0, 0, 0); cyc();
    do_reset();

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      clr();
      for (int i = 0; i < 2; i++)
        set_slot(i, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 31),
                 $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 63), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        pos = $urandom_range(0, 1);
        if (dis_valid[pos]) dis_branch[pos] = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        cdb_valid[k]       = $urandom_range(0, 1);
        cdb_tag[k*6 +: 6]  = 6'($urandom_range(32, 63));
      end
      if (m_ck.size() > 0 && $urandom_range(0, 7) == 0) begin
        pos = $urandom_range(0, m_ck.size() - 1);
        recover_valid = 1'b1;
        recover_id    = m_ck[pos].id;
        retire_ckpt   = (pos > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        retire_ckpt = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end

    clr();
    repeat (2) @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
